rsa_modexp_ctrl: RTL and testbench

Sequencer for RSA modular exponentiation, computing o_a_pow_d = i_a^i_d mod i_n with right-to-left binary exponentiation. It owns the single shared Montgomery multiplier and drives it over an external start/finished handshake on the mm_* ports. The multiplier computes a*b*2^-WIDTH mod n. An internal pre-processing sub-block converts the base into the Montgomery domain before the exponent loop starts. This block sits between the RSA top/wrapper (I/O side) and the montMul instance.

---
 rtl/rsa_pkg.sv | 15 +
 rtl/rsa_modprod.sv | 55 +++++
 rtl/rsa_modexp_ctrl.sv | 128 ++++++++++++
 tb/tb_rsa_modexp_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-exponentiation datapath.
package rsa_pkg;
  localparam int RSA_WIDTH = 256;
  localparam int RSA_CNT_W = $clog2(RSA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_MUL,
    S_WAIT_MUL,
    S_SQR,
    S_WAIT_SQR,
    S_DONE
  } rsa_state_e;
endpackage

// File: rtl/rsa_modprod.sv
// Maps y into the Montgomery domain (y*2^WIDTH mod n) by WIDTH rounds of
// modular doubling; the first round happens on the load edge.
module rsa_modprod
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH,
  parameter int CNT_W = RSA_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_y,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_result,
  output logic             o_finished
);
  logic [WIDTH-1:0] n_q;
  logic [CNT_W-1:0] cnt;
  logic             busy;

  // The doubled value needs WIDTH+1 bits so the compare against n sees the carry.
  function automatic logic [WIDTH-1:0] dbl_mod(input logic [WIDTH-1:0] t,
                                               input logic [WIDTH-1:0] n);
    logic [WIDTH:0] t2;
    t2 = {t, 1'b0};
    if (t2 >= {1'b0, n}) t2 = t2 - {1'b0, n};
    return t2[WIDTH-1:0];
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_result   <= '0;
      o_finished <= 1'b0;
      n_q        <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
    end else begin
      o_finished <= 1'b0;
      if (i_start) begin
        o_result <= dbl_mod(i_y, i_n);
        n_q      <= i_n;
        cnt      <= CNT_W'(1);
        busy     <= 1'b1;
      end else if (busy) begin
        o_result <= dbl_mod(o_result, n_q);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          busy       <= 1'b0;
          o_finished <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: rtl/rsa_modexp_ctrl.sv
// Right-to-left binary modexp sequencer driving one shared Montgomery multiplier.
// m stays in the normal domain (MM(m, tR) = m*t), t stays in the Montgomery domain.
module rsa_modexp_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_a_pow_d,
  output logic             o_finished,
  output logic             o_mm_start,
  output logic [WIDTH-1:0] o_mm_a,
  output logic [WIDTH-1:0] o_mm_b,
  output logic [WIDTH-1:0] o_mm_n,
  input  logic [WIDTH-1:0] i_mm_result,
  input  logic             i_mm_finished,
  output rsa_state_e       o_state
);
  localparam int KW = $clog2(WIDTH);

  rsa_state_e       state;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] d_q;
  logic [KW-1:0]    k;
  logic [KW-1:0]    k_nxt;
  logic             prep_start;
  logic [WIDTH-1:0] prep_result;
  logic             prep_finished;

  assign prep_start = (state == S_IDLE) && i_start;
  assign k_nxt      = k + KW'(1);
  assign o_state    = state;

  rsa_modprod #(.WIDTH(WIDTH), .CNT_W(KW)) u_prep (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (prep_start),
    .i_y        (i_a),
    .i_n        (i_n),
    .o_result   (prep_result),
    .o_finished (prep_finished)
  );

  // Multiplier handshake: o_mm_start is a one-cycle launch with o_mm_a/b/n held
  // until the one-cycle i_mm_finished; only one multiply is ever outstanding.
  // S_MUL/S_SQR are the launch cycles, so operands and o_mm_start are loaded on
  // the edge that enters them; a clear exponent bit skips S_MUL entirely.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      o_a_pow_d  <= '0;
      o_finished <= 1'b0;
      o_mm_start <= 1'b0;
      o_mm_a     <= '0;
      o_mm_b     <= '0;
      o_mm_n     <= '0;
      t          <= '0;
      m          <= '0;
      d_q        <= '0;
      k          <= '0;
    end else begin
      o_finished <= 1'b0;
      o_mm_start <= 1'b0;
      unique case (state)
        S_IDLE: if (i_start) begin
          d_q    <= i_d;
          o_mm_n <= i_n;
          t      <= i_a;
          m      <= WIDTH'(1);
          state  <= S_PREP;
        end
        S_PREP: if (prep_finished) begin
          t          <= prep_result;
          k          <= '0;
          o_mm_start <= 1'b1;
          if (d_q[0]) begin
            o_mm_a <= m;
            o_mm_b <= prep_result;
            state  <= S_MUL;
          end else begin
            o_mm_a <= prep_result;
            o_mm_b <= prep_result;
            state  <= S_SQR;
          end
        end
        S_MUL: state <= S_WAIT_MUL;
        S_WAIT_MUL: if (i_mm_finished) begin
          m          <= i_mm_result;
          o_mm_start <= 1'b1;
          o_mm_a     <= t;
          o_mm_b     <= t;
          state      <= S_SQR;
        end
        S_SQR: state <= S_WAIT_SQR;
        S_WAIT_SQR: if (i_mm_finished) begin
          t <= i_mm_result;
          if (k == KW'(WIDTH - 1)) begin
            state <= S_DONE;
          end else begin
            k          <= k_nxt;
            o_mm_start <= 1'b1;
            if (d_q[k_nxt]) begin
              o_mm_a <= m;
              o_mm_b <= i_mm_result;
              state  <= S_MUL;
            end else begin
              o_mm_a <= i_mm_result;
              o_mm_b <= i_mm_result;
              state  <= S_SQR;
            end
          end
        end
        S_DONE: begin
          o_a_pow_d  <= m;
          o_finished <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Directed bench for rsa_modexp_ctrl at WIDTH=8 with a behavioural Montgomery
// multiplier (a*b*2^-8 mod n, three cycles from start to finished).
module tb_rsa_modexp_ctrl;
  import rsa_pkg::*;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] d     = '0;
  logic [W-1:0] n     = '0;
  logic [W-1:0] a_pow_d;
  logic         finished;
  logic         mm_start;
  logic [W-1:0] mm_a, mm_b, mm_n;
  logic [W-1:0] mm_result = '0;
  logic         mm_finished;
  logic         model_fin = 1'b0;
  logic         stray_fin = 1'b0;
  rsa_state_e   state;

  assign mm_finished = model_fin | stray_fin;

  int n_checks = 0;
  int n_pass   = 0;
  int start_cnt = 0;
  int diff_cnt  = 0;
  int mm_rem    = 0;
  logic         mm_busy    = 1'b0;
  logic         mm_aborted = 1'b0;
  logic [W-1:0] cap_a = '0, cap_b = '0, cap_n = '0;
  logic [W-1:0] exp_q[$];

  rsa_modexp_ctrl #(.WIDTH(W)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_a           (a),
    .i_d           (d),
    .i_n           (n),
    .o_a_pow_d     (a_pow_d),
    .o_finished    (finished),
    .o_mm_start    (mm_start),
    .o_mm_a        (mm_a),
    .o_mm_b        (mm_b),
    .o_mm_n        (mm_n),
    .i_mm_result   (mm_result),
    .i_mm_finished (mm_finished),
    .o_state       (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [W-1:0] mont(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic [W-1:0] md);
    longint acc;
    acc = longint'(x) * longint'(y);
    for (int i = 0; i < W; i++) begin
      if (acc[0]) acc = acc + longint'(md);
      acc = acc >> 1;
    end
    if (acc >= longint'(md)) acc = acc - longint'(md);
    return acc[W-1:0];
  endfunction

  // Montgomery multiplier model; it is not reset, like the real instance.
  always @(posedge clk) begin
    model_fin <= 1'b0;
    if (rst && mm_busy) mm_aborted <= 1'b1;
    if (mm_busy) begin
      if (mm_rem == 1) begin
        model_fin <= 1'b1;
        mm_result <= mont(cap_a, cap_b, cap_n);
        mm_busy   <= 1'b0;
      end else begin
        mm_rem <= mm_rem - 1;
      end
    end
    if (mm_start) begin
      mm_busy    <= 1'b1;
      mm_rem     <= 2;
      cap_a      <= mm_a;
      cap_b      <= mm_b;
      cap_n      <= mm_n;
      mm_aborted <= 1'b0;
      start_cnt++;
      if (mm_a != mm_b) diff_cnt++;
    end
  end

  // scoreboard and handshake monitor
  always @(negedge clk) begin
    if (finished) begin
      check("finish_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("result", a_pow_d, exp_q.pop_front());
    end
    if (mm_start) check("mm_overlap", mm_busy, 0);
    if (model_fin && !mm_aborted) begin
      check("mm_a_stable", mm_a, cap_a);
      check("mm_b_stable", mm_b, cap_b);
    end
  end

  // driver tasks
  task automatic launch(input logic [W-1:0] y, input logic [W-1:0] dd, input logic [W-1:0] nn);
    @(negedge clk);
    a = y; d = dd; n = nn; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!finished && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    check("done_timeout", finished, 1);
  endtask

  task automatic run(input string tag, input logic [W-1:0] y, input logic [W-1:0] dd,
                     input logic [W-1:0] nn, input logic [W-1:0] exp_res,
                     input int exp_lat, input int exp_starts);
    int lat;
    exp_q.push_back(exp_res);
    start_cnt = 0;
    diff_cnt  = 0;
    launch(y, dd, nn);
    wait_done(lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_mm_starts"}, start_cnt, exp_starts);
    @(negedge clk);
    check({tag, "_finish_pulse"}, finished, 0);
    check({tag, "_held"}, a_pow_d, exp_res);
  endtask

  task automatic wait_state(input rsa_state_e s, input string tag);
    int guard = 0;
    while (state != s && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check(tag, state, s);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_state", state, S_IDLE);
    check("rst_pow", a_pow_d, 0);
    check("rst_finished", finished, 0);
    check("rst_mm_start", mm_start, 0);
    check("rst_mm_a", mm_a, 0);
    check("rst_mm_b", mm_b, 0);
    check("rst_mm_n", mm_n, 0);
    rst = 1'b0;

    run("y88_d7", 8'd88, 8'd7, 8'd187, 8'd11, 54, 11);
    check("y88_d7_mults", diff_cnt, 3);
    run("y11_d23", 8'd11, 8'd23, 8'd187, 8'd88, 58, 12);
    run("d0", 8'd5, 8'd0, 8'd187, 8'd1, 42, 8);
    check("d0_mults", diff_cnt, 0);
    run("d1", 8'd5, 8'd1, 8'd187, 8'd5, 46, 9);
    check("d1_mults", diff_cnt, 1);
    run("n251_wide", 8'd250, 8'd3, 8'd251, 8'd250, 50, 10);
    run("d_all_ones", 8'd2, 8'd255, 8'd251, 8'd32, 74, 16);
    run("d_top_bit", 8'd3, 8'd128, 8'd255, 8'd171, 46, 9);
    run("y2_d10", 8'd2, 8'd10, 8'd187, 8'd89, 50, 10);

    // start pulses while busy must be ignored
    exp_q.push_back(8'd11);
    launch(8'd88, 8'd7, 8'd187);
    repeat (2) @(negedge clk);
    check("ign_in_prep", state, S_PREP);
    a = 8'd5; d = 8'd1; n = 8'd251; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_prep_n", mm_n, 187);
    wait_state(S_WAIT_SQR, "ign_reach_wait_sqr");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_wait_n", mm_n, 187);
    wait_done(lat);
    @(negedge clk);
    check("ign_held", a_pow_d, 11);
    run("after_ign", 8'd5, 8'd1, 8'd187, 8'd5, 46, 9);

    // reset in the middle of a multiply, then stray finished pulses
    exp_q.push_back(8'd11);
    launch(8'd88, 8'd7, 8'd187);
    wait_state(S_WAIT_MUL, "rst_reach_wait_mul");
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("rst_mid_state", state, S_IDLE);
    check("rst_mid_pow", a_pow_d, 0);
    check("rst_mid_mm_start", mm_start, 0);
    check("rst_mid_mm_a", mm_a, 0);
    check("rst_mid_mm_n", mm_n, 0);
    @(negedge clk);
    rst = 1'b0;
    stray_fin = 1'b1;
    @(negedge clk);
    stray_fin = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("rst_quiet_state", state, S_IDLE);
      check("rst_quiet_mm_start", mm_start, 0);
      check("rst_quiet_pow", a_pow_d, 0);
    end
    run("after_rst", 8'd88, 8'd7, 8'd187, 8'd11, 54, 11);

    check("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
